// File: rtl/encode_pkg.sv
// -----------------------------------------------------------------------------
// encode_pkg
// Shared declarations for the raw-data encoder sequencer:
//   - state_e         : sequencer states
//   - DEFAULT_NUM_SEG : default number of segments per input word
//   - DEFAULT_CNT_W   : default width of the completed-word counter
// -----------------------------------------------------------------------------
package encode_pkg;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RD_READY = 2'd1,
      ENCODE   = 2'd2,
      RF_FULL  = 2'd3
   } state_e;

   localparam int DEFAULT_NUM_SEG = 4;
   localparam int DEFAULT_CNT_W   = 16;

endpackage : encode_pkg

// File: rtl/encode_seq_fsm_if.sv
// -----------------------------------------------------------------------------
// encode_seq_fsm_if
// Bundles the FIFO-side handshake and encoder control signals of the sequencer.
//   master : the sequencer (reads FIFO status/strobe, drives pops/clears/select)
//   slave  : the FIFO / encoder datapath side
// Signals:
//   raw_data_in_fifo_empty  input FIFO empty (show-ahead)
//   raw_data_in_wstrb       strobe of the head word, bit i = segment i valid
//   raw_data_out_fifo_full  output FIFO full
//   flush_req               level request to clear the output FIFO
//   raw_data_in_*_pop       pop the head of the data/index/strobe FIFOs
//   raw_data_out_*_clr      clear the output data/index FIFOs
//   raw_data_sel            encoder segment select
//   push_enable             push the encoded segment this cycle
//   encoding                high while a word is being encoded
//   encoded_words           count of completed non-empty words
// -----------------------------------------------------------------------------
interface encode_seq_fsm_if
   import encode_pkg::*;
#(
   parameter int NUM_SEG = DEFAULT_NUM_SEG,
   parameter int CNT_W   = DEFAULT_CNT_W
);

   localparam int SEL_W = $clog2(NUM_SEG);

   logic               raw_data_in_fifo_empty;
   logic [NUM_SEG-1:0] raw_data_in_wstrb;
   logic               raw_data_out_fifo_full;
   logic               flush_req;

   logic               raw_data_in_fifo_pop;
   logic               raw_data_in_index_pop;
   logic               raw_data_in_wstrb_pop;
   logic               raw_data_out_fifo_clr;
   logic               raw_data_out_index_clr;
   logic [SEL_W-1:0]   raw_data_sel;
   logic               push_enable;
   logic               encoding;
   logic [CNT_W-1:0]   encoded_words;

   modport master (
      input  raw_data_in_fifo_empty,
      input  raw_data_in_wstrb,
      input  raw_data_out_fifo_full,
      input  flush_req,
      output raw_data_in_fifo_pop,
      output raw_data_in_index_pop,
      output raw_data_in_wstrb_pop,
      output raw_data_out_fifo_clr,
      output raw_data_out_index_clr,
      output raw_data_sel,
      output push_enable,
      output encoding,
      output encoded_words
   );

   modport slave (
      output raw_data_in_fifo_empty,
      output raw_data_in_wstrb,
      output raw_data_out_fifo_full,
      output flush_req,
      input  raw_data_in_fifo_pop,
      input  raw_data_in_index_pop,
      input  raw_data_in_wstrb_pop,
      input  raw_data_out_fifo_clr,
      input  raw_data_out_index_clr,
      input  raw_data_sel,
      input  push_enable,
      input  encoding,
      input  encoded_words
   );

endinterface : encode_seq_fsm_if

// File: rtl/encode_seq_fsm_seg_prio_enc.sv
// -----------------------------------------------------------------------------
// seg_prio_enc
// Find-first-set over a NUM_SEG-bit vector, considering only bits whose index
// is >= base. base is one bit wider than an index so that "one past the last
// segment" is representable and simply yields found = 0.
// Ports:
//   vec   in  NUM_SEG   vector to search
//   base  in  SEL_W+1   lowest index considered
//   idx   out SEL_W     index of the lowest qualifying set bit (0 if none)
//   found out 1         a qualifying set bit exists
// -----------------------------------------------------------------------------
module seg_prio_enc
   import encode_pkg::*;
#(
   parameter  int NUM_SEG = DEFAULT_NUM_SEG,
   localparam int SEL_W   = $clog2(NUM_SEG)
) (
   input  logic [NUM_SEG-1:0] vec,
   input  logic [SEL_W:0]     base,
   output logic [SEL_W-1:0]   idx,
   output logic               found
);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      // Scan downward so the last hit written is the lowest qualifying bit.
      for (int i = NUM_SEG - 1; i >= 0; i--) begin
         if (vec[i] && ((SEL_W+1)'(i) >= base)) begin
            idx   = SEL_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule : seg_prio_enc

// File: rtl/encode_seq_fsm.sv
// -----------------------------------------------------------------------------
// encode_seq_fsm
// Control sequencer for the raw-data encoder path. Drains words from the
// show-ahead input FIFO, steps the encoder mux over the valid segments of
// each word (one push per cycle), skips clear-strobe segments, discards
// all-zero-strobe words in one cycle, stalls on output-FIFO full, and handles
// a flush request that re-initialises the output FIFO.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   bus    master modport of encode_seq_fsm_if (FIFO status in, control out)
// All control outputs are forced to 0 while reset is high, so an abandoned
// word is never popped.
// -----------------------------------------------------------------------------
module encode_seq_fsm
   import encode_pkg::*;
#(
   parameter int NUM_SEG = DEFAULT_NUM_SEG,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input logic                clk,
   input logic                reset,
   encode_seq_fsm_if.master   bus
);

   localparam int SEL_W = $clog2(NUM_SEG);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] seg_q,   seg_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [SEL_W-1:0] first_idx, next_idx;
   logic             first_found, next_found;
   logic [SEL_W:0]   next_base;
   logic [SEL_W:0]   zero_base;

   logic pop, push, clr, enc;

   // First valid segment of the head word.
   assign zero_base = '0;

   seg_prio_enc #(.NUM_SEG(NUM_SEG)) u_first_seg (
      .vec   (bus.raw_data_in_wstrb),
      .base  (zero_base),
      .idx   (first_idx),
      .found (first_found)
   );

   // Next valid segment strictly above the current one.
   assign next_base = {1'b0, seg_q} + (SEL_W+1)'(1);

   seg_prio_enc #(.NUM_SEG(NUM_SEG)) u_next_seg (
      .vec   (bus.raw_data_in_wstrb),
      .base  (next_base),
      .idx   (next_idx),
      .found (next_found)
   );

   always_comb begin
      state_d = state_q;
      seg_d   = seg_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      push    = 1'b0;
      clr     = 1'b0;
      enc     = 1'b0;

      unique case (state_q)
         INIT: begin
            clr     = 1'b1;
            cnt_d   = '0;
            seg_d   = '0;
            state_d = RD_READY;
         end

         RD_READY: begin
            if (bus.flush_req) begin
               state_d = INIT;
            end else if (bus.raw_data_in_fifo_empty) begin
               state_d = RD_READY;
            end else if (!first_found) begin
               // All-zero strobe: discard the word without encoding it.
               pop = 1'b1;
            end else if (bus.raw_data_out_fifo_full) begin
               seg_d   = first_idx;
               state_d = RF_FULL;
            end else begin
               seg_d   = first_idx;
               state_d = ENCODE;
            end
         end

         ENCODE: begin
            enc = 1'b1;
            if (!bus.raw_data_out_fifo_full) begin
               push = 1'b1;
               if (!next_found) begin
                  // Last valid segment: pop coincides with its push.
                  pop     = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = RD_READY;
               end else begin
                  seg_d = next_idx;
               end
            end else begin
               state_d = RF_FULL;
            end
         end

         RF_FULL: begin
            enc = 1'b1;
            if (!bus.raw_data_out_fifo_full) begin
               state_d = ENCODE;
            end
         end

         default: state_d = INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         seg_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         seg_q   <= seg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.raw_data_in_fifo_pop   = pop  & ~reset;
   assign bus.raw_data_in_index_pop  = pop  & ~reset;
   assign bus.raw_data_in_wstrb_pop  = pop  & ~reset;
   assign bus.raw_data_out_fifo_clr  = clr  & ~reset;
   assign bus.raw_data_out_index_clr = clr  & ~reset;
   assign bus.push_enable            = push & ~reset;
   assign bus.encoding               = enc  & ~reset;
   assign bus.raw_data_sel           = reset ? '0 : seg_q;
   assign bus.encoded_words          = reset ? '0 : cnt_q;

endmodule : encode_seq_fsm

// File: tb/tb_encode_seq_fsm.sv
// -----------------------------------------------------------------------------
// tb_encode_seq_fsm
// Directed, cycle-by-cycle bench for encode_seq_fsm with NUM_SEG = 4.
// Inputs are driven 1 time unit after each rising edge; outputs are compared
// mid-cycle against hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_encode_seq_fsm;

   logic clk;
   logic reset;

   int n_cmp = 0;
   int n_err = 0;

   encode_seq_fsm_if #(.NUM_SEG(4), .CNT_W(16)) bus ();

   encode_seq_fsm #(.NUM_SEG(4), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, compare all outputs mid-cycle, advance.
   task automatic cyc(
      input string       tag,
      input logic        rst,
      input logic        emp,
      input logic [3:0]  ws,
      input logic        full,
      input logic        fl,
      input logic [1:0]  e_sel,
      input logic        e_push,
      input logic        e_pop,
      input logic        e_clr,
      input logic        e_enc,
      input logic [15:0] e_cnt
   );
      reset                      = rst;
      bus.raw_data_in_fifo_empty = emp;
      bus.raw_data_in_wstrb      = ws;
      bus.raw_data_out_fifo_full = full;
      bus.flush_req              = fl;
      #4;
      check({tag, ".sel"},       32'(bus.raw_data_sel),           32'(e_sel));
      check({tag, ".push"},      32'(bus.push_enable),            32'(e_push));
      check({tag, ".fifo_pop"},  32'(bus.raw_data_in_fifo_pop),   32'(e_pop));
      check({tag, ".index_pop"}, 32'(bus.raw_data_in_index_pop),  32'(e_pop));
      check({tag, ".wstrb_pop"}, 32'(bus.raw_data_in_wstrb_pop),  32'(e_pop));
      check({tag, ".fifo_clr"},  32'(bus.raw_data_out_fifo_clr),  32'(e_clr));
      check({tag, ".index_clr"}, 32'(bus.raw_data_out_index_clr), 32'(e_clr));
      check({tag, ".encoding"},  32'(bus.encoding),               32'(e_enc));
      check({tag, ".words"},     32'(bus.encoded_words),          32'(e_cnt));
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset                      = 1'b1;
      bus.raw_data_in_fifo_empty = 1'b1;
      bus.raw_data_in_wstrb      = 4'b0000;
      bus.raw_data_out_fifo_full = 1'b0;
      bus.flush_req              = 1'b0;
      @(posedge clk);
      #1;

      //   tag          rst emp wstrb    full fl  sel   push pop clr enc words
      // Reset held two cycles, then release: one clr pulse, then idle.
      cyc("rst0",       1, 1, 4'b0000, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);
      cyc("rst1",       1, 1, 4'b0000, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);
      cyc("init",       0, 1, 4'b0000, 0, 0, 2'd0, 0, 0, 1, 0, 16'd0);
      cyc("idle",       0, 1, 4'b0000, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);

      // Full-strobe word: sel 0..3, pop with sel 3.
      cyc("w1_rd",      0, 0, 4'b1111, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);
      cyc("w1_s0",      0, 0, 4'b1111, 0, 0, 2'd0, 1, 0, 0, 1, 16'd0);
      cyc("w1_s1",      0, 0, 4'b1111, 0, 0, 2'd1, 1, 0, 0, 1, 16'd0);
      cyc("w1_s2",      0, 0, 4'b1111, 0, 0, 2'd2, 1, 0, 0, 1, 16'd0);
      cyc("w1_s3",      0, 0, 4'b1111, 0, 0, 2'd3, 1, 1, 0, 1, 16'd0);

      // Sparse strobe 1010: sel 1 then 3.
      cyc("w2_rd",      0, 0, 4'b1010, 0, 0, 2'd3, 0, 0, 0, 0, 16'd1);
      cyc("w2_s1",      0, 0, 4'b1010, 0, 0, 2'd1, 1, 0, 0, 1, 16'd1);
      cyc("w2_s3",      0, 0, 4'b1010, 0, 0, 2'd3, 1, 1, 0, 1, 16'd1);

      // All-zero strobe: single-cycle pop, no push, counter unchanged.
      cyc("w0_rd",      0, 0, 4'b0000, 0, 0, 2'd3, 0, 1, 0, 0, 16'd2);

      // Full during sel 2 for two cycles.
      cyc("w3_rd",      0, 0, 4'b1111, 0, 0, 2'd3, 0, 0, 0, 0, 16'd2);
      cyc("w3_s0",      0, 0, 4'b1111, 0, 0, 2'd0, 1, 0, 0, 1, 16'd2);
      cyc("w3_s1",      0, 0, 4'b1111, 0, 0, 2'd1, 1, 0, 0, 1, 16'd2);
      cyc("w3_s2_full", 0, 0, 4'b1111, 1, 0, 2'd2, 0, 0, 0, 1, 16'd2);
      cyc("w3_rf_full", 0, 0, 4'b1111, 1, 0, 2'd2, 0, 0, 0, 1, 16'd2);
      cyc("w3_rf_free", 0, 0, 4'b1111, 0, 0, 2'd2, 0, 0, 0, 1, 16'd2);
      cyc("w3_s2",      0, 0, 4'b1111, 0, 0, 2'd2, 1, 0, 0, 1, 16'd2);
      cyc("w3_s3",      0, 0, 4'b1111, 0, 0, 2'd3, 1, 1, 0, 1, 16'd2);

      // Flush raised mid-word: word completes, then INIT clears the counter.
      cyc("w4_rd",      0, 0, 4'b1111, 0, 0, 2'd3, 0, 0, 0, 0, 16'd3);
      cyc("w4_s0",      0, 0, 4'b1111, 0, 1, 2'd0, 1, 0, 0, 1, 16'd3);
      cyc("w4_s1",      0, 0, 4'b1111, 0, 1, 2'd1, 1, 0, 0, 1, 16'd3);
      cyc("w4_s2",      0, 0, 4'b1111, 0, 1, 2'd2, 1, 0, 0, 1, 16'd3);
      cyc("w4_s3",      0, 0, 4'b1111, 0, 1, 2'd3, 1, 1, 0, 1, 16'd3);
      cyc("fl_rd",      0, 1, 4'b0000, 0, 1, 2'd3, 0, 0, 0, 0, 16'd4);
      cyc("fl_init",    0, 1, 4'b0000, 0, 0, 2'd3, 0, 0, 1, 0, 16'd4);
      cyc("fl_rd2",     0, 1, 4'b0000, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);

      // Reset mid-word at sel 1: no pop, INIT after release, one clr pulse.
      cyc("w5_rd",      0, 0, 4'b1111, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);
      cyc("w5_s0",      0, 0, 4'b1111, 0, 0, 2'd0, 1, 0, 0, 1, 16'd0);
      cyc("w5_rst",     1, 0, 4'b1111, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);
      cyc("w5_init",    0, 1, 4'b0000, 0, 0, 2'd0, 0, 0, 1, 0, 16'd0);
      cyc("w5_idle",    0, 1, 4'b0000, 0, 0, 2'd0, 0, 0, 0, 0, 16'd0);

      // Single-segment word arriving while full: RF_FULL first, then one push+pop.
      cyc("w6_rd_full", 0, 0, 4'b0100, 1, 0, 2'd0, 0, 0, 0, 0, 16'd0);
      cyc("w6_rf_free", 0, 0, 4'b0100, 0, 0, 2'd2, 0, 0, 0, 1, 16'd0);
      cyc("w6_s2",      0, 0, 4'b0100, 0, 0, 2'd2, 1, 1, 0, 1, 16'd0);
      cyc("w6_done",    0, 1, 4'b0000, 0, 0, 2'd2, 0, 0, 0, 0, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_encode_seq_fsm
